// File: rtl/quick_cpu_pc_unit.sv
// Program-counter / control-flow unit: stall, jump, call/return via a hardware
// return stack, sticky halt and sticky stack-error reporting.
module quick_cpu_pc_unit #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STACK_DEPTH = 4,
  parameter int                SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              halted,
  output logic              stack_err,
  output logic [SP_W-1:0]   sp
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              push;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (en) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else if (call && ret) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else if (ret) begin
            if (sp_q != '0) begin
              pc_d = stack_q[rd_idx];
              sp_d = sp_q - SP_W'(1);
            end else begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end
          end else if (call) begin
            if (sp_q != SP_W'(STACK_DEPTH)) begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
              pc_d = jump_addr;
            end else begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end
          end else if (jump) begin
            pc_d = jump_addr;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack contents survive reset; only sp marks which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= pc_q + ADDR_W'(1);
  end

  assign pc        = pc_q;
  assign sp        = sp_q;
  assign stack_err = err_q;
  assign pc_valid  = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_quick_cpu_pc_unit.sv
// Self-checking bench for quick_cpu_pc_unit: directed scenarios plus randomized
// control traffic against a queue-based reference model.
module tb_quick_cpu_pc_unit;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int SP_W   = 3;
  localparam int RVEC   = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, halt_req = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid, halted, stack_err;
  logic [SP_W-1:0]   sp;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit m_boot, m_halt, m_err;
  int m_pc;
  int m_stk[$];

  quick_cpu_pc_unit #(
    .ADDR_W(ADDR_W),
    .RESET_VEC(8'(RVEC)),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .jump(jump), .call(call), .ret(ret),
    .halt_req(halt_req), .jump_addr(jump_addr), .pc(pc), .pc_valid(pc_valid),
    .halted(halted), .stack_err(stack_err), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_pc   = RVEC;
    m_stk.delete();
  endtask

  task automatic model_fail();
    m_err  = 1'b1;
    m_halt = 1'b1;
  endtask

  task automatic model_update();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt && en) begin
      if (halt_req)               m_halt = 1'b1;
      else if (call && ret)       model_fail();
      else if (ret) begin
        if (m_stk.size() > 0)     m_pc = m_stk.pop_back();
        else                      model_fail();
      end else if (call) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % (1 << ADDR_W));
          m_pc = int'(jump_addr);
        end else                  model_fail();
      end else if (jump)          m_pc = int'(jump_addr);
      else                        m_pc = (m_pc + 1) % (1 << ADDR_W);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc),        32'(m_pc));
    check({tag, ".valid"}, 32'(pc_valid),  32'(!m_boot && !m_halt));
    check({tag, ".halt"},  32'(halted),    32'(m_halt));
    check({tag, ".err"},   32'(stack_err), 32'(m_err));
    check({tag, ".sp"},    32'(sp),        32'(m_stk.size()));
  endtask

  task automatic set_in(input logic e, input logic j, input logic c, input logic r,
                        input logic h, input logic [ADDR_W-1:0] a);
    en = e; jump = j; call = c; ret = r; halt_req = h; jump_addr = a;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all(tag);
  endtask

  // Assert reset away from edges, check the reset state, release on a falling edge.
  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // 1: boot cycle then increment through a full wrap
    do_reset();
    step("boot");
    check("t1_first_pc", 32'(pc), 32'(RVEC));
    for (int i = 0; i < 257; i++) step("inc");
    check("t1_wrap_pc", 32'(pc), 32'h01);

    // 2: call at pc=0x10, return to 0x11
    do_reset();
    step("boot");
    for (int i = 0; i < 16; i++) step("t2_run");
    check("t2_at10", 32'(pc), 32'h10);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
    step("t2_call");
    check("t2_pc40", 32'(pc), 32'h40);
    check("t2_sp1", 32'(sp), 32'd1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step("t2_idle");
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step("t2_ret");
    check("t2_pc11", 32'(pc), 32'h11);
    check("t2_sp0", 32'(sp), 32'd0);

    // 3: five nested calls overflow a depth-4 stack
    do_reset();
    step("boot");
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h20 + 8'(i * 16)));
      step("t3_call");
    end
    check("t3_err", 32'(stack_err), 32'd1);
    check("t3_sp", 32'(sp), 32'd4);
    check("t3_pc", 32'(pc), 32'h50);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
    for (int i = 0; i < 3; i++) step("t3_frozen");

    // 4: underflow, then call+ret collision
    do_reset();
    step("boot");
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step("t4_under");
    check("t4_under_err", 32'(stack_err), 32'd1);
    do_reset();
    step("boot");
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    step("t4_call");
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    step("t4_coll");
    check("t4_coll_sp", 32'(sp), 32'd1);
    check("t4_coll_halt", 32'(halted), 32'd1);

    // 5: stall with jump held, then halt_req
    do_reset();
    step("boot");
    step("t5_run");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < 3; i++) step("t5_stall");
    check("t5_hold", 32'(pc), 32'h01);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step("t5_halt");
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step("t5_halted");
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_no_err", 32'(stack_err), 32'd0);

    // 6: asynchronous reset mid-cycle with two entries on the stack
    do_reset();
    step("boot");
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60);
    step("t6_call1");
    step("t6_call2");
    check("t6_sp2", 32'(sp), 32'd2);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    model_update();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t6_async_pc", 32'(pc), 32'(RVEC));
    check("t6_async_sp", 32'(sp), 32'd0);
    check("t6_async_valid", 32'(pc_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("t6_boot");

    // Randomized control traffic in reset-delimited segments
    for (int s = 0; s < 20; s++) begin
      do_reset();
      step("r_boot");
      for (int c = 0; c < 150; c++) begin
        set_in(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 12),
               ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 10),
               ($urandom_range(0, 199) == 0), 8'($urandom_range(0, 255)));
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
